vga_timing_gen: RTL

- Upstream stage of the text-mode character renderer.
- Generates the 640x480@60 Hz raster position (hindex, vindex), the sync pulses and the active-video qualifier from the 25 MHz pixel clock.
- hindex/vindex feed the renderer directly. hsync/vsync go to the VGA connector.
- A run/stop handshake lets the system start and stop scanning only on frame boundaries.

---
 rtl/vga_timing_gen_if.sv | 26 ++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 2 files changed

// File: rtl/vga_timing_gen_if.sv
// Raster-timing bundle between vga_timing_gen (slave) and the system/renderer side (master).
interface vga_timing_gen_if;
    logic       run;
    logic [9:0] hindex;
    logic [9:0] vindex;
    logic       hsync;
    logic       vsync;
    logic       display_en;
    logic       line_start;
    logic       frame_start;
    logic [7:0] frame_count;
    logic       busy;
    logic       blink;

    modport master (
        output run,
        input  hindex, vindex, hsync, vsync, display_en, line_start,
               frame_start, frame_count, busy, blink
    );

    modport slave (
        input  run,
        output hindex, vindex, hsync, vsync, display_en, line_start,
               frame_start, frame_count, busy, blink
    );
endinterface

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster generator with frame-aligned run/stop; all outputs registered from next-state values.
// Optional cursor blink phase is built only when VGA_TIMING_BLINK_EN is defined.
module vga_timing_gen #(
    parameter int H_VISIBLE = 640,
    parameter int H_FRONT   = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BACK    = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FRONT   = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BACK    = 33
) (
    input  logic            clk25mhz,
    input  logic            reset_n,
    vga_timing_gen_if.slave vga
);
    localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

    generate
        if (H_TOTAL > 1024 || V_TOTAL > 1024) begin : g_bad_totals
            $fatal(1, "vga_timing_gen: H_TOTAL and V_TOTAL must not exceed 1024");
        end
    endgenerate

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS      = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS      = 10'(V_VISIBLE);
    localparam logic [9:0] HS_FIRST   = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_LAST    = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
    localparam logic [9:0] VS_FIRST   = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_LAST    = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACTIVE   = 2'd1,
        S_STOPPING = 2'd2
    } state_t;

    state_t     r_state, w_state_next;
    logic [9:0] r_hindex, r_vindex, w_hindex_next, w_vindex_next;
    logic [7:0] r_frame_count, w_frame_count_next;
    logic       r_hsync, r_vsync, r_display_en, r_line_start, r_frame_start, r_busy;
    logic       w_frame_end, w_busy_next;

    assign w_frame_end = (r_hindex == H_LAST) && (r_vindex == V_LAST);

    always_comb begin
        w_state_next       = r_state;
        w_hindex_next      = r_hindex;
        w_vindex_next      = r_vindex;
        w_frame_count_next = r_frame_count;
        case (r_state)
            S_IDLE: begin
                w_hindex_next = '0;
                w_vindex_next = '0;
                if (vga.run) w_state_next = S_ACTIVE;
            end
            S_ACTIVE, S_STOPPING: begin
                if (r_hindex == H_LAST) begin
                    w_hindex_next = '0;
                    w_vindex_next = (r_vindex == V_LAST) ? 10'd0 : r_vindex + 10'd1;
                end else begin
                    w_hindex_next = r_hindex + 10'd1;
                end
                // A stop request only takes effect on the frame boundary; run=1 cancels it.
                if (w_frame_end) begin
                    w_frame_count_next = r_frame_count + 8'd1;
                    w_state_next       = vga.run ? S_ACTIVE : S_IDLE;
                end else begin
                    w_state_next       = vga.run ? S_ACTIVE : S_STOPPING;
                end
            end
            default: begin
                w_state_next  = S_IDLE;
                w_hindex_next = '0;
                w_vindex_next = '0;
            end
        endcase
    end

    assign w_busy_next = (w_state_next != S_IDLE);

    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= S_IDLE;
            r_hindex      <= '0;
            r_vindex      <= '0;
            r_frame_count <= '0;
            r_hsync       <= 1'b1;
            r_vsync       <= 1'b1;
            r_display_en  <= 1'b0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_hindex      <= w_hindex_next;
            r_vindex      <= w_vindex_next;
            r_frame_count <= w_frame_count_next;
            // Decodes use the next position so they line up with the registered indices.
            r_hsync       <= !(w_busy_next && w_hindex_next >= HS_FIRST && w_hindex_next <= HS_LAST);
            r_vsync       <= !(w_busy_next && w_vindex_next >= VS_FIRST && w_vindex_next <= VS_LAST);
            r_display_en  <= w_busy_next && (w_hindex_next < H_VIS) && (w_vindex_next < V_VIS);
            r_line_start  <= w_busy_next && (w_hindex_next == 10'd0);
            r_frame_start <= w_busy_next && (w_hindex_next == 10'd0) && (w_vindex_next == 10'd0);
            r_busy        <= w_busy_next;
        end
    end

`ifdef VGA_TIMING_BLINK_EN
    logic r_blink;

    always_ff @(posedge clk25mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_blink <= 1'b0;
        end else if ((w_frame_count_next != r_frame_count) && (r_frame_count[4:0] == 5'h1f)) begin
            r_blink <= ~r_blink;
        end
    end

    assign vga.blink = r_blink;
`else
    assign vga.blink = 1'b0;
`endif

    assign vga.hindex      = r_hindex;
    assign vga.vindex      = r_vindex;
    assign vga.hsync       = r_hsync;
    assign vga.vsync       = r_vsync;
    assign vga.display_en  = r_display_en;
    assign vga.line_start  = r_line_start;
    assign vga.frame_start = r_frame_start;
    assign vga.frame_count = r_frame_count;
    assign vga.busy        = r_busy;
endmodule
